// File: rtl/col_parity_pkg.sv
// rtl/col_parity_pkg.sv - shared widths, mode/state encodings and column parity helper
package col_parity_pkg;

    localparam int SLICE_W = 25;
    localparam int ROWS    = 5;
    localparam int COLS    = 5;

    typedef enum logic [1:0] {
        MODE_THETA  = 2'd0,
        MODE_PARITY = 2'd1,
        MODE_BYPASS = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Bit x of the result is the XOR of column x over all five rows (bit index 5*y + x).
    function automatic logic [COLS-1:0] col_parity(input logic [SLICE_W-1:0] s);
        logic [COLS-1:0] p;
        p = '0;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                p[x] = p[x] ^ s[COLS*y + x];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/slice_theta.sv
// rtl/slice_theta.sv - combinational output slice: theta, parity-only or bypass
module slice_theta
    import col_parity_pkg::*;
(
    input  logic [SLICE_W-1:0] slice_a,
    input  logic [COLS-1:0]    par_cur,
    input  logic [COLS-1:0]    par_prev,
    input  logic [1:0]         mode,
    output logic [SLICE_W-1:0] slice_o
);

    logic [SLICE_W-1:0] theta;

    always_comb begin
        theta = '0;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                theta[COLS*y + x] = slice_a[COLS*y + x]
                                  ^ par_cur[(x + 4) % COLS]
                                  ^ par_prev[(x + 1) % COLS];
            end
        end
    end

    always_comb begin
        slice_o = slice_a;
        case (mode)
            MODE_THETA:  slice_o = theta;
            MODE_PARITY: slice_o = {{(SLICE_W-COLS){1'b0}}, par_cur};
            default:     slice_o = slice_a;
        endcase
    end

endmodule

// File: rtl/col_parity_engine.sv
// rtl/col_parity_engine.sv - load DEPTH slices, then drain theta/parity/bypass results
module col_parity_engine
    import col_parity_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    output logic               ready,
    input  logic               inValid,
    output logic               inReady,
    input  logic [SLICE_W-1:0] sliceIn,
    output logic               outValid,
    input  logic               outReady,
    output logic [SLICE_W-1:0] sliceOut,
    output logic               done
);

    localparam int             IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0]  LAST = IW'(DEPTH - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [1:0]      mode_q, mode_d;
    logic            done_q, done_d;

    logic [SLICE_W-1:0] buf_q [DEPTH];
    logic [COLS-1:0]    par_q [DEPTH];

    logic               load_fire;
    logic [IW-1:0]      prev_idx;
    logic [SLICE_W-1:0] theta_slice;

    assign ready     = (state_q == ST_IDLE);
    assign inReady   = (state_q == ST_LOAD);
    assign outValid  = (state_q == ST_DRAIN);
    assign done      = done_q;
    assign load_fire = inReady && inValid;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    mode_d  = mode;
                end
            end
            ST_LOAD: begin
                if (inValid) begin
                    if (idx_q == LAST) begin
                        state_d = ST_DRAIN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (outReady) begin
                    if (idx_q == LAST) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mode_q  <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // Storage is intentionally unreset; it is fully rewritten before any drain reads it.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            buf_q[idx_q] <= sliceIn;
            par_q[idx_q] <= col_parity(sliceIn);
        end
    end

    // Slice 0 pairs with slice DEPTH-1; for DEPTH == 1 LAST is 0, so it pairs with itself.
    assign prev_idx = (idx_q == '0) ? LAST : idx_q - 1'b1;

    slice_theta u_slice_theta (
        .slice_a  (buf_q[idx_q]),
        .par_cur  (par_q[idx_q]),
        .par_prev (par_q[prev_idx]),
        .mode     (mode_q),
        .slice_o  (theta_slice)
    );

    assign sliceOut = outValid ? theta_slice : '0;

endmodule

// File: tb/tb_col_parity_engine.sv
// tb/tb_col_parity_engine.sv - scoreboard bench for col_parity_engine (DEPTH 64 and 4)
module tb_col_parity_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic        in_valid;
    logic [24:0] slice_in;
    logic        out_ready;
    logic        sel4;

    logic        rdy64, ir64, ov64, dn64;
    logic [24:0] so64;
    logic        rdy4, ir4, ov4, dn4;
    logic [24:0] so4;

    logic        start64, start4, iv64, iv4, or64, or4;
    logic        ready, in_ready, out_valid, done;
    logic [24:0] slice_out;

    assign start64   = start & ~sel4;
    assign start4    = start & sel4;
    assign iv64      = in_valid & ~sel4;
    assign iv4       = in_valid & sel4;
    assign or64      = out_ready & ~sel4;
    assign or4       = out_ready & sel4;
    assign ready     = sel4 ? rdy4 : rdy64;
    assign in_ready  = sel4 ? ir4 : ir64;
    assign out_valid = sel4 ? ov4 : ov64;
    assign done      = sel4 ? dn4 : dn64;
    assign slice_out = sel4 ? so4 : so64;

    col_parity_engine #(.DEPTH(64)) u_dut64 (
        .clk(clk), .rst(rst), .start(start64), .mode(mode), .ready(rdy64),
        .inValid(iv64), .inReady(ir64), .sliceIn(slice_in),
        .outValid(ov64), .outReady(or64), .sliceOut(so64), .done(dn64)
    );

    col_parity_engine #(.DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode), .ready(rdy4),
        .inValid(iv4), .inReady(ir4), .sliceIn(slice_in),
        .outValid(ov4), .outReady(or4), .sliceOut(so4), .done(dn4)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [24:0] stim    [64];
    logic [24:0] exp_tbl [64];
    bit          use_tbl;
    logic [24:0] exp_q [$];

    function automatic logic [4:0] cp(input logic [24:0] s);
        logic [4:0] p;
        p = '0;
        for (int x = 0; x < 5; x++)
            p[x] = s[x] ^ s[5+x] ^ s[10+x] ^ s[15+x] ^ s[20+x];
        return p;
    endfunction

    function automatic logic [24:0] model_out(input int z, input int n, input logic [1:0] md);
        logic [24:0] r;
        logic [4:0]  pc, pp;
        pc = cp(stim[z]);
        pp = cp(stim[(z + n - 1) % n]);
        r  = stim[z];
        if (md == 2'd0) begin
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    r[5*y+x] = stim[z][5*y+x] ^ pc[(x+4)%5] ^ pp[(x+1)%5];
        end else if (md == 2'd1) begin
            r = {20'b0, pc};
        end
        return r;
    endfunction

    task automatic run_op(input bit use4, input logic [1:0] md, input bit gap_en,
                          input int bp_idx, input int abort_idx);
        int          n;
        int          i;
        int          oi;
        int          cyc;
        int          hold;
        bit          gap;
        logic [24:0] held;
        logic [24:0] expv;
        n    = use4 ? 4 : 64;
        sel4 = use4;
        cyc  = 0;
        while (!ready && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait: ready=%b required 1", ready);
            return;
        end
        start = 1'b1;
        mode  = md;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done=%b required 0 one cycle after pulse", done);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL enter_load: inReady=%b required 1", in_ready);
        end
        i   = 0;
        cyc = 0;
        while (i < n && cyc < 1000) begin
            gap      = gap_en && ($urandom_range(0, 2) == 0);
            start    = gap;
            mode     = gap ? ~md : md;
            in_valid = !gap;
            slice_in = gap ? 25'($urandom) : stim[i];
            if (!gap) i++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        mode     = md;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_latency: outValid=%b inReady=%b required 1/0", out_valid, in_ready);
        end
        for (int z = 0; z < n; z++)
            exp_q.push_back(use_tbl ? exp_tbl[z] : model_out(z, n, md));
        oi   = 0;
        hold = 0;
        cyc  = 0;
        held = '0;
        while (oi < n && cyc < 2000) begin
            if (oi == abort_idx) begin
                rst = 1'b0;
                #1;
                checks++;
                if (ready !== 1'b1 || out_valid !== 1'b0 || slice_out !== 25'd0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_reset: ready=%b outValid=%b sliceOut=%h done=%b required 1/0/0/0",
                             ready, out_valid, slice_out, done);
                end
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                checks++;
                if (done !== 1'b0 || ready !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_no_done: done=%b ready=%b required 0/1", done, ready);
                end
                exp_q.delete();
                out_ready = 1'b0;
                return;
            end
            if (oi == bp_idx && hold < 3) begin
                out_ready = 1'b0;
                if (hold == 0) begin
                    held = slice_out;
                end else begin
                    checks++;
                    if (slice_out !== held || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL backpressure_hold: sliceOut=%h outValid=%b required %h/1",
                                 slice_out, out_valid, held);
                    end
                end
                hold++;
            end else begin
                out_ready = 1'b1;
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : 25'h0;
                checks++;
                if (out_valid !== 1'b1 || done !== 1'b0 || slice_out !== expv) begin
                    errors++;
                    $display("FAIL slice_out[%0d] mode %0d depth %0d: got %h v=%b d=%b required %h v=1 d=0",
                             oi, md, n, slice_out, out_valid, done, expv);
                end
                oi++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (oi != n || done !== 1'b1 || ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: transfers=%0d done=%b ready=%b outValid=%b required %0d/1/1/0",
                     oi, done, ready, out_valid, n);
        end
    endtask

    task automatic clear_stim();
        for (int k = 0; k < 64; k++) begin
            stim[k]    = '0;
            exp_tbl[k] = '0;
        end
    endtask

    task automatic random_stim();
        for (int k = 0; k < 64; k++) stim[k] = 25'($urandom);
        use_tbl = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rdy64 !== 1'b1 || ir64 !== 1'b0 || ov64 !== 1'b0 || dn64 !== 1'b0 || so64 !== 25'd0) begin
            errors++;
            $display("FAIL reset64: ready=%b inReady=%b outValid=%b done=%b sliceOut=%h required 1/0/0/0/0",
                     rdy64, ir64, ov64, dn64, so64);
        end
        checks++;
        if (rdy4 !== 1'b1 || ir4 !== 1'b0 || ov4 !== 1'b0 || dn4 !== 1'b0 || so4 !== 25'd0) begin
            errors++;
            $display("FAIL reset4: ready=%b inReady=%b outValid=%b done=%b sliceOut=%h required 1/0/0/0/0",
                     rdy4, ir4, ov4, dn4, so4);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_theta_zero();
        clear_stim();
        use_tbl = 1'b1;
        run_op(1'b0, 2'd0, 1'b0, -1, -1);
    endtask

    task automatic test_theta_slice0();
        clear_stim();
        stim[0]    = 25'h0000001;
        exp_tbl[0] = 25'h0210843;
        exp_tbl[1] = 25'h1084210;
        use_tbl    = 1'b1;
        run_op(1'b0, 2'd0, 1'b0, -1, -1);
    endtask

    task automatic test_theta_wrap();
        clear_stim();
        stim[63]    = 25'h0000001;
        exp_tbl[63] = 25'h0210843;
        exp_tbl[0]  = 25'h1084210;
        use_tbl     = 1'b1;
        run_op(1'b0, 2'd0, 1'b0, -1, -1);
    endtask

    task automatic test_parity4();
        clear_stim();
        stim[0] = 25'h1FFFFFF; exp_tbl[0] = 25'h1F;
        stim[1] = 25'h0000001; exp_tbl[1] = 25'h01;
        stim[2] = 25'h0000000; exp_tbl[2] = 25'h00;
        stim[3] = 25'h0000020; exp_tbl[3] = 25'h01;
        use_tbl = 1'b1;
        run_op(1'b1, 2'd1, 1'b0, -1, -1);
    endtask

    task automatic test_bypass4();
        clear_stim();
        for (int k = 0; k < 4; k++) begin
            stim[k]    = 25'($urandom);
            exp_tbl[k] = stim[k];
        end
        use_tbl = 1'b1;
        run_op(1'b1, 2'd2, 1'b0, -1, -1);
        run_op(1'b1, 2'd3, 1'b1, 2, -1);
    endtask

    task automatic test_backpressure_gaps();
        random_stim();
        run_op(1'b0, 2'd0, 1'b1, 5, -1);
    endtask

    task automatic test_back_to_back();
        random_stim();
        run_op(1'b0, 2'd1, 1'b0, -1, -1);
        random_stim();
        run_op(1'b0, 2'd0, 1'b1, 17, -1);
    endtask

    task automatic test_abort();
        random_stim();
        run_op(1'b0, 2'd0, 1'b0, -1, 10);
        random_stim();
        run_op(1'b0, 2'd0, 1'b0, -1, -1);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        mode      = 2'd0;
        in_valid  = 1'b0;
        slice_in  = '0;
        out_ready = 1'b0;
        sel4      = 1'b0;
        use_tbl   = 1'b0;
        test_reset();
        test_theta_zero();
        test_theta_slice0();
        test_theta_wrap();
        test_parity4();
        test_bypass4();
        test_backpressure_gaps();
        test_back_to_back();
        test_abort();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
